// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word loads and stores, a power-up
// init sweep, and a registered one-cycle load/fault response.
module data_mem_ctrl #(
  parameter int          DEPTH      = 256,
  parameter logic [31:0] INIT_VALUE = 32'h00000000
) (
  input  logic        clk,
  input  logic        SYS_reset_n,
  input  logic [31:0] DMEM_address,
  input  logic [31:0] DMEM_data_in,
  input  logic        DMEM_mem_write,
  input  logic        DMEM_mem_read,
  input  logic [1:0]  DMEM_size,
  input  logic        DMEM_unsigned,
  output logic [31:0] DMEM_data_out,
  output logic        DMEM_valid,
  output logic        DMEM_ready,
  output logic        DMEM_misaligned
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] widx_p0;
  logic [1:0]    off_p0;
  logic          mis_p0;
  logic          store_ok_p0;
  logic [3:0]    be_p0;
  logic [31:0]   wd_p0;
  logic [31:0]   data_p1;
  logic          vld_p1;
  logic          mis_p1;
  logic          unused_addr_hi;

  // Extract the addressed lane and widen it; words ignore the unsigned flag.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (sz)
      2'b00:   return uns ? {24'd0, sh[7:0]}  : 32'(b);
      2'b01:   return uns ? {16'd0, sh[15:0]} : 32'(h);
      default: return w;
    endcase
  endfunction

  assign DMEM_ready     = (state_q == IDLE);
  assign widx_p0        = DMEM_address[AW+1:2];
  assign off_p0         = DMEM_address[1:0];
  assign unused_addr_hi = ^DMEM_address[31:AW+2];

  assign mis_p0 = (DMEM_size == 2'b11) ||
                  (DMEM_size == 2'b01 && off_p0[0]) ||
                  (DMEM_size == 2'b10 && off_p0 != 2'b00);

  assign store_ok_p0 = DMEM_ready && DMEM_mem_write && !mis_p0;

  always_comb begin
    be_p0 = 4'b0000;
    wd_p0 = DMEM_data_in;
    case (DMEM_size)
      2'b00: begin
        be_p0 = 4'b0001 << off_p0;
        wd_p0 = {4{DMEM_data_in[7:0]}};
      end
      2'b01: begin
        be_p0 = 4'b0011 << {off_p0[1], 1'b0};
        wd_p0 = {2{DMEM_data_in[15:0]}};
      end
      2'b10:   be_p0 = 4'b1111;
      default: be_p0 = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && idx_q == LAST) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) idx_q <= idx_q + AW'(1);
    end
  end

  // Array has no reset: its contents come only from the init sweep.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[idx_q] <= INIT_VALUE;
    end else if (store_ok_p0) begin
      for (int i = 0; i < 4; i++)
        if (be_p0[i]) mem[widx_p0][8*i +: 8] <= wd_p0[8*i +: 8];
    end
  end

  // p0 -> p1: response register; a write wins over a simultaneous read.
  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      mis_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      mis_p1 <= 1'b0;
      if (DMEM_ready && DMEM_mem_write) begin
        if (mis_p0) begin
          vld_p1  <= 1'b1;
          mis_p1  <= 1'b1;
          data_p1 <= '0;
        end
      end else if (DMEM_ready && DMEM_mem_read) begin
        vld_p1  <= 1'b1;
        mis_p1  <= mis_p0;
        data_p1 <= mis_p0 ? 32'd0 : load_ext(mem[widx_p0], off_p0, DMEM_size, DMEM_unsigned);
      end
    end
  end

  assign DMEM_data_out   = data_p1;
  assign DMEM_valid      = vld_p1;
  assign DMEM_misaligned = mis_p1;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (DEPTH=256, INIT_VALUE=0).
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        SYS_reset_n = 1'b0;
  logic [31:0] DMEM_address = '0;
  logic [31:0] DMEM_data_in = '0;
  logic        DMEM_mem_write = 1'b0;
  logic        DMEM_mem_read = 1'b0;
  logic [1:0]  DMEM_size = 2'b10;
  logic        DMEM_unsigned = 1'b0;
  logic [31:0] DMEM_data_out;
  logic        DMEM_valid;
  logic        DMEM_ready;
  logic        DMEM_misaligned;

  int total = 0;
  int bad   = 0;

  data_mem_ctrl #(.DEPTH(256), .INIT_VALUE(32'h00000000)) dut (
    .clk            (clk),
    .SYS_reset_n    (SYS_reset_n),
    .DMEM_address   (DMEM_address),
    .DMEM_data_in   (DMEM_data_in),
    .DMEM_mem_write (DMEM_mem_write),
    .DMEM_mem_read  (DMEM_mem_read),
    .DMEM_size      (DMEM_size),
    .DMEM_unsigned  (DMEM_unsigned),
    .DMEM_data_out  (DMEM_data_out),
    .DMEM_valid     (DMEM_valid),
    .DMEM_ready     (DMEM_ready),
    .DMEM_misaligned(DMEM_misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request held across a single rising edge; response is visible on return.
  task automatic req(input logic w, input logic r, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    DMEM_mem_write = w;
    DMEM_mem_read  = r;
    DMEM_size      = sz;
    DMEM_unsigned  = u;
    DMEM_address   = a;
    DMEM_data_in   = d;
    step();
    DMEM_mem_write = 1'b0;
    DMEM_mem_read  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({DMEM_valid, DMEM_ready, DMEM_misaligned, DMEM_data_out} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b r=%b m=%b d=%h want all 0",
               DMEM_valid, DMEM_ready, DMEM_misaligned, DMEM_data_out);
    end
  endtask

  task automatic test_init_ready();
    int n = 0;
    SYS_reset_n = 1'b1;
    #1;
    total++;
    if (DMEM_ready !== 1'b0) begin bad++; $display("FAIL ready_after_release got=%b want=0", DMEM_ready); end
    while (DMEM_ready !== 1'b1 && n < 400) begin step(); n++; end
    total++;
    if (n != 256) begin bad++; $display("FAIL init_cycles got=%0d want=256", n); end
    req(0, 1, 2'b10, 0, 32'h3FC, 0);
    total++;
    if ({DMEM_valid, DMEM_misaligned, DMEM_data_out} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL lw_3fc got v=%b m=%b d=%h want v=1 m=0 d=00000000",
                      DMEM_valid, DMEM_misaligned, DMEM_data_out);
    end
  endtask

  task automatic test_byte_word();
    req(1, 0, 2'b10, 0, 32'h10, 32'h11223344);
    total++;
    if (DMEM_valid !== 1'b0) begin bad++; $display("FAIL sw_no_valid got=%b want=0", DMEM_valid); end
    req(0, 1, 2'b00, 0, 32'h11, 0);
    total++;
    if (DMEM_valid !== 1'b1 || DMEM_data_out !== 32'h00000033) begin
      bad++; $display("FAIL lb_11 got v=%b d=%h want v=1 d=00000033", DMEM_valid, DMEM_data_out);
    end
    req(1, 0, 2'b00, 0, 32'h12, 32'h000000FF);
    req(0, 1, 2'b00, 0, 32'h12, 0);
    total++;
    if (DMEM_data_out !== 32'hFFFFFFFF) begin bad++; $display("FAIL lb_12 got=%h want=ffffffff", DMEM_data_out); end
    req(0, 1, 2'b00, 1, 32'h12, 0);
    total++;
    if (DMEM_data_out !== 32'h000000FF) begin bad++; $display("FAIL lbu_12 got=%h want=000000ff", DMEM_data_out); end
    req(0, 1, 2'b10, 0, 32'h10, 0);
    total++;
    if (DMEM_data_out !== 32'h11FF3344) begin bad++; $display("FAIL lw_10 got=%h want=11ff3344", DMEM_data_out); end
    step();
    total++;
    if ({DMEM_valid, DMEM_misaligned, DMEM_data_out} !== {2'b00, 32'h11FF3344}) begin
      bad++; $display("FAIL idle_hold got v=%b m=%b d=%h want v=0 m=0 d=11ff3344",
                      DMEM_valid, DMEM_misaligned, DMEM_data_out);
    end
  endtask

  task automatic test_half();
    req(1, 0, 2'b01, 0, 32'h22, 32'h00008001);
    req(0, 1, 2'b01, 0, 32'h22, 0);
    total++;
    if (DMEM_data_out !== 32'hFFFF8001) begin bad++; $display("FAIL lh_22 got=%h want=ffff8001", DMEM_data_out); end
    req(0, 1, 2'b01, 1, 32'h22, 0);
    total++;
    if (DMEM_data_out !== 32'h00008001) begin bad++; $display("FAIL lhu_22 got=%h want=00008001", DMEM_data_out); end
    req(0, 1, 2'b10, 1, 32'h20, 0);
    total++;
    if (DMEM_data_out !== 32'h80010000) begin bad++; $display("FAIL lw_20 got=%h want=80010000", DMEM_data_out); end
  endtask

  task automatic test_misaligned();
    req(0, 1, 2'b10, 0, 32'h06, 0);
    total++;
    if ({DMEM_valid, DMEM_misaligned, DMEM_data_out} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL lw_06_mis got v=%b m=%b d=%h want v=1 m=1 d=0",
                      DMEM_valid, DMEM_misaligned, DMEM_data_out);
    end
    req(1, 0, 2'b01, 0, 32'h05, 32'h0000AAAA);
    total++;
    if ({DMEM_valid, DMEM_misaligned, DMEM_data_out} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL sh_05_mis got v=%b m=%b d=%h want v=1 m=1 d=0",
                      DMEM_valid, DMEM_misaligned, DMEM_data_out);
    end
    req(0, 1, 2'b10, 0, 32'h04, 0);
    total++;
    if ({DMEM_valid, DMEM_misaligned, DMEM_data_out} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL lw_04_unchanged got v=%b m=%b d=%h want v=1 m=0 d=0",
                      DMEM_valid, DMEM_misaligned, DMEM_data_out);
    end
    req(0, 1, 2'b11, 0, 32'h00, 0);
    total++;
    if ({DMEM_valid, DMEM_misaligned} !== 2'b11) begin
      bad++; $display("FAIL size11_mis got v=%b m=%b want v=1 m=1", DMEM_valid, DMEM_misaligned);
    end
    step();
    total++;
    if ({DMEM_valid, DMEM_misaligned} !== 2'b00) begin
      bad++; $display("FAIL mis_clears got v=%b m=%b want v=0 m=0", DMEM_valid, DMEM_misaligned);
    end
  endtask

  task automatic test_back_to_back();
    req(1, 0, 2'b10, 0, 32'h400, 32'hCAFEBABE);
    req(0, 1, 2'b10, 0, 32'h000, 0);
    total++;
    if (DMEM_valid !== 1'b1 || DMEM_data_out !== 32'hCAFEBABE) begin
      bad++; $display("FAIL wrap_lw_0 got v=%b d=%h want v=1 d=cafebabe", DMEM_valid, DMEM_data_out);
    end
    req(1, 0, 2'b10, 0, 32'h30, 32'h12345678);
    req(0, 1, 2'b10, 0, 32'h30, 0);
    total++;
    if (DMEM_data_out !== 32'h12345678) begin bad++; $display("FAIL b2b_lw_30 got=%h want=12345678", DMEM_data_out); end
    req(1, 1, 2'b10, 0, 32'h40, 32'hDEADBEEF);
    total++;
    if (DMEM_valid !== 1'b0) begin bad++; $display("FAIL rw_no_valid got=%b want=0", DMEM_valid); end
    req(0, 1, 2'b10, 0, 32'h40, 0);
    total++;
    if (DMEM_data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL rw_store_done got=%h want=deadbeef", DMEM_data_out); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic seen = 1'b0;
    req(0, 1, 2'b10, 0, 32'h000, 0);
    SYS_reset_n = 1'b0;
    #1;
    total++;
    if ({DMEM_valid, DMEM_ready, DMEM_misaligned, DMEM_data_out} !== 35'd0) begin
      bad++; $display("FAIL reset_drops_load got v=%b r=%b m=%b d=%h want all 0",
                      DMEM_valid, DMEM_ready, DMEM_misaligned, DMEM_data_out);
    end
    step();
    SYS_reset_n = 1'b1;
    repeat (100) step();
    SYS_reset_n = 1'b0;
    #1;
    total++;
    if ({DMEM_valid, DMEM_ready, DMEM_misaligned, DMEM_data_out} !== 35'd0) begin
      bad++; $display("FAIL reset_mid_init got v=%b r=%b m=%b d=%h want all 0",
                      DMEM_valid, DMEM_ready, DMEM_misaligned, DMEM_data_out);
    end
    step();
    SYS_reset_n = 1'b1;
    while (DMEM_ready !== 1'b1 && n < 400) begin
      DMEM_mem_read = 1'b1;
      DMEM_size     = 2'b10;
      DMEM_address  = 32'h0;
      step();
      n++;
      if (DMEM_valid === 1'b1) seen = 1'b1;
    end
    DMEM_mem_read = 1'b0;
    total++;
    if (n != 256) begin bad++; $display("FAIL reinit_cycles got=%0d want=256", n); end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL init_req_ignored got valid=%b want=0", seen); end
    req(0, 1, 2'b10, 0, 32'h000, 0);
    total++;
    if (DMEM_valid !== 1'b1 || DMEM_data_out !== 32'h0) begin
      bad++; $display("FAIL reinit_clears got v=%b d=%h want v=1 d=00000000", DMEM_valid, DMEM_data_out);
    end
  endtask

  initial begin
    test_reset();
    step();
    test_init_ready();
    test_byte_word();
    test_half();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
